// File: rtl/router_merge_rr.sv
// Purpose  : 4-to-1 round-robin merge of valid/ready streams into one registered
//            output. Each beat is tagged on dout_addr with its source index.
// Latency  : 1 clk from acceptance to dout_valid; sustained 1 beat/clk.
// Backpress: a held beat blocks acceptance (din_ready=0) until dout_ready frees it.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   din0..din3          source data buses (DATA_WIDTH)
//   din_valid/din_ready per-source handshake; din_ready is one-hot or zero
//   dout, dout_addr     registered merged data and its source index
//   dout_valid/ready    output handshake
//   beat_cnt            [15:0] saturating count of consumed output beats,
//                       present only when ROUTER_MERGE_CNT_EN is defined
module router_merge_rr #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [DATA_WIDTH-1:0] din2,
  input  logic [DATA_WIDTH-1:0] din3,
  input  logic [3:0]            din_valid,
  output logic [3:0]            din_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            dout_addr,
  output logic                  dout_valid,
  input  logic                  dout_ready
`ifdef ROUTER_MERGE_CNT_EN
  ,
  output logic [15:0]           beat_cnt
`endif
);

  typedef struct packed {
    logic [1:0]            addr;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  beat_t                 out_q;
  logic                  out_vld_q;
  logic [1:0]            last_grant;

  logic                  load;
  logic [1:0]            grant;
  logic                  found;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_data;

  assign load = !out_vld_q || dout_ready;

  // Search starts one past the last winner; k=4 wraps back onto last_grant
  // itself so a lone requester is always found.
  always_comb begin
    grant = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] cand;
      cand = last_grant + k[1:0];
      if (!found && din_valid[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  // rst_n gates din_ready so a source never sees a handshake that the
  // reset edge is about to throw away.
  always_comb begin
    din_ready = 4'b0000;
    if (load && found && rst_n) begin
      din_ready = 4'b0001 << grant;
    end
  end

  assign accept = |din_ready;

  always_comb begin
    sel_data = din0;
    case (grant)
      2'd0:    sel_data = din0;
      2'd1:    sel_data = din1;
      2'd2:    sel_data = din2;
      default: sel_data = din3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      last_grant <= 2'd3;
    end else if (accept) begin
      // Covers both an empty register and consume+accept in the same edge.
      out_q.addr <= grant;
      out_q.data <= sel_data;
      out_vld_q  <= 1'b1;
      last_grant <= grant;
    end else if (dout_ready) begin
      // Data and address keep their last values; only valid drops.
      out_vld_q  <= 1'b0;
    end
  end

  assign dout       = out_q.data;
  assign dout_addr  = out_q.addr;
  assign dout_valid = out_vld_q;

`ifdef ROUTER_MERGE_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt <= 16'h0000;
    end else if (out_vld_q && dout_ready && beat_cnt != 16'hFFFF) begin
      beat_cnt <= beat_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: doc/router_merge_rr.md
Name: router_merge_rr

Overview:
4-to-1 collector; the return-path counterpart of the 1-to-4 address router. Four source streams arbitrate round-robin for one registered output. Each forwarded beat is tagged with its source index on dout_addr, so a downstream router can steer replies back. Valid/ready handshake on every port; one-beat output register.

Parameters:
DATA_WIDTH, 32, width of every data bus.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
din0  input  DATA_WIDTH  source 0 data
din1  input  DATA_WIDTH  source 1 data
din2  input  DATA_WIDTH  source 2 data
din3  input  DATA_WIDTH  source 3 data
din_valid  input  4  bit i = source i presents a beat
din_ready  output  4  bit i = source i beat accepted this cycle (one-hot or zero)
dout  output  DATA_WIDTH  merged data (registered)
dout_addr  output  2  source index of beat on dout (registered)
dout_valid  output  1  dout/dout_addr hold a beat
dout_ready  input  1  sink accepts beat this cycle

Behaviour:
- One clock, clk. Reset is synchronous and active-low (rst_n); sampled only on rising clk.
- Reset values: dout=0, dout_addr=0, dout_valid=0, last_grant=3 (first-round priority 0,1,2,3). While rst_n=0, din_ready=0.
- load = !dout_valid | dout_ready (combinational).
- Arbiter: search din_valid starting at (last_grant+1) mod 4, wrapping; first set bit is grant g. din_ready = onehot(g) when load & |din_valid & rst_n, else 0. Combinational din_valid->din_ready path is permitted.
- Acceptance (din_valid[g] & din_ready[g]): next edge dout<=din_g, dout_addr<=g, dout_valid<=1, last_grant<=g. Latency: exactly 1 cycle from acceptance to dout_valid.
- Pointer moves only on acceptance; no acceptance leaves last_grant unchanged.
- Output consumed (dout_valid & dout_ready) with no new acceptance: dout_valid<=0; dout and dout_addr hold their last values.
- Simultaneous consume + accept: the new beat replaces the old one in the same edge. Sustained throughput is 1 beat/clk.
- Stall (dout_valid & !dout_ready): dout, dout_addr and dout_valid remain stable; din_ready=0.
- Fairness: with all four sources continuously valid and the sink always ready, grants cycle 0,1,2,3,0,... Any valid source waits at most 3 accepted beats.
- Single requester: granted every load cycle regardless of pointer.
- Reset mid-operation: the held beat is discarded and no din_ready is issued in that cycle. Sources must re-present their beats.
- Data bits are passed through unmodified; no width conversion.

Optional Feature:
ROUTER_MERGE_CNT_EN
- Defined: adds output beat_cnt [15:0]. It increments on each output consume (dout_valid & dout_ready), saturates at 16'hFFFF, and resets to 0 on rst_n=0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 2 clks with all din_valid=1 -> din_ready=0, dout_valid=0, dout=0, dout_addr=0 throughout. On release the first grant goes to source 0.
- Round-robin: din0..3=A0,B1,C2,D3, din_valid=4'hF, dout_ready=1 for 8 clks -> dout_addr sequence 0,1,2,3,0,1,2,3 with 1-clk latency, one beat per clk.
- Backpressure: single beat 32'hDEADBEEF from source 2, dout_ready=0 for 3 clks -> dout, dout_addr=2 and dout_valid=1 held stable, din_ready=0. When dout_ready=1 the beat is consumed; the next beat appears the following clk.
- Pointer hold: only source 1 valid for 2 beats, then sources 0 and 1 both valid -> source 0 is granted next, because the search starts after last_grant=1 and wraps to 0.
- Mid-stream reset: rst_n=0 while dout_valid=1 and dout_ready=0 -> next clk dout_valid=0 and the beat is dropped. After release, priority restarts at source 0.
- ROUTER_MERGE_CNT_EN defined: consume 5 beats -> beat_cnt=5. Force the count to 16'hFFFE, then consume 3 beats -> beat_cnt=16'hFFFF.
